// File: rtl/dcm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcm_pkg
// Purpose  : Shared limits, defaults and helpers for the dcm_dfs frequency
//            synthesizer (phase-accumulator CLKFX path).
// Contents : MUL_MAX / DIV_MAX / LOCK_MAX limits, DEFAULT_* parameter values,
//            acc_width() returning the accumulator width for a given DIV.
// Revision : 1.0 - initial release
// ============================================================================
package dcm_pkg;

  localparam int MUL_MAX             = 16;
  localparam int DIV_MAX             = 32;
  localparam int LOCK_MAX            = 4095;

  localparam int DEFAULT_DIV         = 5;
  localparam int DEFAULT_MUL         = 2;
  localparam int DEFAULT_LOCK_CYCLES = 16;

  // The accumulator never holds more than DIV-1, but the intermediate sum
  // acc + 2*MUL can reach 2*DIV-1, so the width is sized for 2*DIV.
  function automatic int acc_width(input int div);
    return $clog2(2 * div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dfs_phase_acc.sv
`default_nettype none
// ============================================================================
// Module   : dfs_phase_acc
// Purpose  : Bresenham phase accumulator plus the registered toggle flop that
//            forms the CLKFX square wave (rate = xtal * MUL / DIV).
// Ports    : xtal     in  input clock (rising edge)
//            rst      in  synchronous active-high reset
//            enable   in  run the accumulator; when low acc/clkfx/clkfx_en
//                         are held at 0
//            clkfx    out registered square wave
//            clkfx_en out one-cycle pulse in the cycle clkfx becomes 1
// Revision : 1.0 - initial release
// ============================================================================
module dfs_phase_acc
  import dcm_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV,
  parameter int MUL = DEFAULT_MUL
) (
  input  logic xtal,
  input  logic rst,
  input  logic enable,
  output logic clkfx,
  output logic clkfx_en
);

  localparam int AW = acc_width(DIV);
  localparam logic [AW-1:0] STEP  = AW'(2 * MUL);
  localparam logic [AW-1:0] DIV_V = AW'(DIV);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          wrap;

  always_comb begin
    sum  = acc + STEP;
    wrap = (sum >= DIV_V);
  end

  // Every wrap of the accumulator is one half-period of clkfx. clkfx_en is
  // computed from the pre-toggle value so it lines up with the rising edge.
  always_ff @(posedge xtal) begin
    if (rst || !enable) begin
      acc      <= '0;
      clkfx    <= 1'b0;
      clkfx_en <= 1'b0;
    end else if (wrap) begin
      acc      <= sum - DIV_V;
      clkfx    <= ~clkfx;
      clkfx_en <= ~clkfx;
    end else begin
      acc      <= sum;
      clkfx_en <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcm_dfs.sv
`default_nettype none
// ============================================================================
// Module   : dcm_dfs
// Purpose  : Digital frequency synthesizer modelled on the DCM_SP CLKFX path
//            with a single-flop (glitch-free) output and a lock indicator.
//            Output rate = xtal * MUL / DIV, requires 2*MUL <= DIV.
// Ports    : xtal     in  input clock; all logic on its rising edge
//            rst      in  synchronous active-high reset
//            clkfx    out registered square wave at xtal * MUL / DIV
//            clkfx_en out one-cycle pulse on the cycle clkfx goes 0->1
//            locked   out high once LOCK_CYCLES cycles have elapsed
// Macro    : DCM_STARTUP_WAIT_EN - when defined, the accumulator and outputs
//            are held at 0 until locked rises.
// Revision : 1.0 - initial release
// ============================================================================
module dcm_dfs
  import dcm_pkg::*;
#(
  parameter int DIV         = DEFAULT_DIV,
  parameter int MUL         = DEFAULT_MUL,
  parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
  input  logic xtal,
  input  logic rst,
  output logic clkfx,
  output logic clkfx_en,
  output logic locked
);

  generate
    if (DIV < 2 || DIV > DIV_MAX) begin : g_bad_div
      $error("dcm_dfs: DIV=%0d outside 2..%0d", DIV, DIV_MAX);
    end
    if (MUL < 1 || MUL > MUL_MAX) begin : g_bad_mul
      $error("dcm_dfs: MUL=%0d outside 1..%0d", MUL, MUL_MAX);
    end
    if (2 * MUL > DIV) begin : g_bad_ratio
      $error("dcm_dfs: 2*MUL=%0d exceeds DIV=%0d", 2 * MUL, DIV);
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > LOCK_MAX) begin : g_bad_lock
      $error("dcm_dfs: LOCK_CYCLES=%0d outside 1..%0d", LOCK_CYCLES, LOCK_MAX);
    end
  endgenerate

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_V = LW'(LOCK_CYCLES);

  logic [LW-1:0] lock_cnt;
  logic          phase_en;

  // locked compares the pre-increment count, so it rises one cycle after the
  // counter saturates.
  always_ff @(posedge xtal) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (lock_cnt != LOCK_V) begin
        lock_cnt <= lock_cnt + LW'(1);
      end
      locked <= (lock_cnt == LOCK_V);
    end
  end

`ifdef DCM_STARTUP_WAIT_EN
  assign phase_en = locked;
`else
  assign phase_en = 1'b1;
`endif

  dfs_phase_acc #(
    .DIV (DIV),
    .MUL (MUL)
  ) u_phase (
    .xtal     (xtal),
    .rst      (rst),
    .enable   (phase_en),
    .clkfx    (clkfx),
    .clkfx_en (clkfx_en)
  );

endmodule
`default_nettype wire

// File: tb/tb_dcm_dfs.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcm_dfs
// Purpose  : Self-checking bench for dcm_dfs. Three instances share the clock
//            and reset: DIV=5/MUL=2, DIV=4/MUL=2 and DIV=32/MUL=1, all with
//            LOCK_CYCLES=16. Expected per-cycle values are hand-derived and
//            held in a table; rate checks count edges over fixed windows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcm_dfs;

  logic xtal = 1'b0;
  logic rst  = 1'b1;

  logic fx5, en5, lk5;
  logic fx4, en4, lk4;
  logic fx32, en32, lk32;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int acc5;
    int fx5;
    int en5;
    int fx4;
    int en4;
    int lk;
  } vec_t;

  vec_t tbl [20];

`ifdef DCM_STARTUP_WAIT_EN
  localparam int SKIP = 17;
`else
  localparam int SKIP = 0;
`endif

  dcm_dfs #(.DIV(5), .MUL(2), .LOCK_CYCLES(16)) dut5 (
    .xtal(xtal), .rst(rst), .clkfx(fx5), .clkfx_en(en5), .locked(lk5));

  dcm_dfs #(.DIV(4), .MUL(2), .LOCK_CYCLES(16)) dut4 (
    .xtal(xtal), .rst(rst), .clkfx(fx4), .clkfx_en(en4), .locked(lk4));

  dcm_dfs #(.DIV(32), .MUL(1), .LOCK_CYCLES(16)) dut32 (
    .xtal(xtal), .rst(rst), .clkfx(fx32), .clkfx_en(en32), .locked(lk32));

  always #5 xtal = ~xtal;

  task automatic step();
    @(posedge xtal);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " acc5"},  int'(dut5.u_phase.acc), 0);
    chk({tag, " fx5"},   int'(fx5),  0);
    chk({tag, " en5"},   int'(en5),  0);
    chk({tag, " lk5"},   int'(lk5),  0);
    chk({tag, " fx4"},   int'(fx4),  0);
    chk({tag, " en4"},   int'(en4),  0);
    chk({tag, " fx32"},  int'(fx32), 0);
    chk({tag, " lk32"},  int'(lk32), 0);
  endtask

  // Applies 20 cycles after reset release; k is the number of rising edges
  // seen with rst low.
  task automatic run_table(input string tag);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("%s k%0d acc5", tag, k), int'(dut5.u_phase.acc), tbl[k-1].acc5);
      chk($sformatf("%s k%0d fx5",  tag, k), int'(fx5), tbl[k-1].fx5);
      chk($sformatf("%s k%0d en5",  tag, k), int'(en5), tbl[k-1].en5);
      chk($sformatf("%s k%0d fx4",  tag, k), int'(fx4), tbl[k-1].fx4);
      chk($sformatf("%s k%0d en4",  tag, k), int'(en4), tbl[k-1].en4);
      chk($sformatf("%s k%0d lk5",  tag, k), int'(lk5), tbl[k-1].lk);
    end
  endtask

  initial begin
    int tog5, ren5, tog4, ren4, ren32;
    logic p5, p4;

`ifdef DCM_STARTUP_WAIT_EN
    // Everything held until locked rises after edge 17; first accumulation
    // on edge 18.
    for (int i = 0; i < 17; i++) tbl[i] = '{0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 1};
    tbl[17] = '{4, 0, 0, 1, 1, 1};
    tbl[18] = '{3, 1, 1, 0, 0, 1};
    tbl[19] = '{2, 0, 0, 1, 1, 1};
`else
    // DIV=5: acc 4,3,2,1,0 repeating; toggles on 4 of 5 edges.
    // DIV=4: toggles every edge, rising on odd k.
    tbl[0]  = '{4, 0, 0, 1, 1, 0};
    tbl[1]  = '{3, 1, 1, 0, 0, 0};
    tbl[2]  = '{2, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 0};
    tbl[5]  = '{4, 0, 0, 0, 0, 0};
    tbl[6]  = '{3, 1, 1, 1, 1, 0};
    tbl[7]  = '{2, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0};
    tbl[10] = '{4, 0, 0, 1, 1, 0};
    tbl[11] = '{3, 1, 1, 0, 0, 0};
    tbl[12] = '{2, 0, 0, 1, 1, 0};
    tbl[13] = '{1, 1, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 1, 0};
    tbl[15] = '{4, 0, 0, 0, 0, 0};
    tbl[16] = '{3, 1, 1, 1, 1, 1};
    tbl[17] = '{2, 0, 0, 0, 0, 1};
    tbl[18] = '{1, 1, 1, 1, 1, 1};
    tbl[19] = '{0, 0, 0, 0, 0, 1};
`endif

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    chk_reset_state("reset");

    rst = 1'b0;
    run_table("p1");

    // Run on, then a single-cycle reset mid-operation.
    repeat (7) step();
    chk("pre-rst lk5", int'(lk5), 1);
    rst = 1'b1;
    step();
    chk_reset_state("midrst");
    rst = 1'b0;
    run_table("p2");

    // Rate windows, starting once the output is allowed to run.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (SKIP) step();
    p5 = fx5;
    p4 = fx4;
    tog5 = 0; ren5 = 0; tog4 = 0; ren4 = 0; ren32 = 0;
    for (int c = 1; c <= 320; c++) begin
      step();
      if (c <= 100) begin
        if (fx5 != p5) tog5++;
        if (en5) ren5++;
        if (fx4 != p4) tog4++;
        if (en4) ren4++;
      end
      if (en32) ren32++;
      p5 = fx5;
      p4 = fx4;
    end
    chk("rate5 toggles/100",   tog5,  80);
    chk("rate5 en/100",        ren5,  40);
    chk("rate4 toggles/100",   tog4,  100);
    chk("rate4 en/100",        ren4,  50);
    chk("rate32 en/320",       ren32, 10);
    chk("final lk5",           int'(lk5),  1);
    chk("final lk4",           int'(lk4),  1);
    chk("final lk32",          int'(lk32), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
